// File: rtl/mmu_sequencer_if.sv
// Signal bundle between mmu_sequencer, the two operand buffers, the MMU array and the host.
interface mmu_sequencer_if #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int AW = 32,
  parameter int KW = 8
);
  logic                   start_i;
  logic [KW-1:0]          k_len_i;
  logic                   busy_o;
  logic                   done_o;
  logic                   act_rd_en_o;
  logic [KW-1:0]          act_rd_addr_o;
  logic [N-1:0][DW-1:0]   act_rd_data_i;
  logic                   wgt_rd_en_o;
  logic [KW-1:0]          wgt_rd_addr_o;
  logic [N-1:0][DW-1:0]   wgt_rd_data_i;
  logic                   mmu_valid_o;
  logic [N-1:0][DW-1:0]   mmu_act_o;
  logic [N-1:0][DW-1:0]   mmu_wgt_o;
  logic                   mmu_valid_i;
  logic [N-1:0][AW-1:0]   mmu_psum_i;
  logic                   result_valid_o;
  logic [N-1:0][AW-1:0]   result_o;

  modport master (
    input  start_i, k_len_i, act_rd_data_i, wgt_rd_data_i, mmu_valid_i, mmu_psum_i,
    output busy_o, done_o, act_rd_en_o, act_rd_addr_o, wgt_rd_en_o, wgt_rd_addr_o,
           mmu_valid_o, mmu_act_o, mmu_wgt_o, result_valid_o, result_o
  );

  modport slave (
    output start_i, k_len_i, act_rd_data_i, wgt_rd_data_i, mmu_valid_i, mmu_psum_i,
    input  busy_o, done_o, act_rd_en_o, act_rd_addr_o, wgt_rd_en_o, wgt_rd_addr_o,
           mmu_valid_o, mmu_act_o, mmu_wgt_o, result_valid_o, result_o
  );
endinterface

// File: rtl/mmu_sequencer.sv
// Runs one matrix-multiply pass: fetch K operand vectors, skew them into the
// systolic array, wait for the array to drain and capture the row partial sums.
//   state | meaning
//   IDLE  | waiting for start_i
//   FETCH | issuing buffer reads 0..K-1
//   DRAIN | skew pipeline and array emptying, then capture
//   DONE  | one-cycle done_o pulse
module mmu_sequencer #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int AW = 32,
  parameter int KW = 8
) (
  input  logic             clk,
  input  logic             rst,
  mmu_sequencer_if.master  bus
);

  localparam int CW = $clog2(2 * N);
  localparam logic [CW-1:0] CNT_LAST = CW'(2 * N - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t               state_q, state_d;
  logic [KW-1:0]        k_q, k_d;
  logic [KW-1:0]        addr_q, addr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 rd_vld_q;
  logic [N-2:0]         vld_q;
  logic [N-1:0][AW-1:0] result_q, result_d;
  logic                 result_vld_q, result_vld_d;
  logic                 rd_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      k_q          <= '0;
      addr_q       <= '0;
      cnt_q        <= '0;
      rd_vld_q     <= 1'b0;
      vld_q        <= '0;
      result_q     <= '0;
      result_vld_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      rd_vld_q     <= rd_en;
      result_q     <= result_d;
      result_vld_q <= result_vld_d;
      // vld_q[j] marks lane-0-aligned data sitting in skew stage j
      vld_q[0]     <= rd_vld_q;
      for (int j = 1; j < N - 1; j++) vld_q[j] <= vld_q[j-1];
    end
  end

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    result_d     = result_q;
    result_vld_d = result_vld_q;
    rd_en        = 1'b0;
    case (state_q)
      IDLE: begin
        addr_d = '0;
        cnt_d  = '0;
        if (bus.start_i) begin
          k_d          = bus.k_len_i;
          result_vld_d = 1'b0;
          if (bus.k_len_i == '0) begin
            result_d     = '0;
            result_vld_d = 1'b1;
            state_d      = DONE;
          end else begin
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        rd_en = 1'b1;
        if (addr_q == k_q - KW'(1)) state_d = DRAIN;
        else                        addr_d  = addr_q + KW'(1);
      end
      DRAIN: begin
        // counter restarts while the last lane-0 data is still in flight
        if (rd_vld_q || vld_q[0]) begin
          cnt_d = '0;
        end else if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + CW'(1);
        end else if (!bus.mmu_valid_i) begin
          result_d     = bus.mmu_psum_i;
          result_vld_d = 1'b1;
          state_d      = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  for (genvar r = 0; r < N; r++) begin : g_lane
    logic [r:0][DW-1:0] act_q, act_d, wgt_q, wgt_d;

    always_comb begin
      act_d    = '0;
      wgt_d    = '0;
      act_d[0] = rd_vld_q ? bus.act_rd_data_i[r] : '0;
      wgt_d[0] = rd_vld_q ? bus.wgt_rd_data_i[r] : '0;
      for (int j = 1; j <= r; j++) begin
        act_d[j] = vld_q[j-1] ? act_q[j-1] : '0;
        wgt_d[j] = vld_q[j-1] ? wgt_q[j-1] : '0;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        act_q <= '0;
        wgt_q <= '0;
      end else begin
        act_q <= act_d;
        wgt_q <= wgt_d;
      end
    end

    assign bus.mmu_act_o[r] = act_q[r];
    assign bus.mmu_wgt_o[r] = wgt_q[r];
  end

  assign bus.busy_o         = (state_q != IDLE);
  assign bus.done_o         = (state_q == DONE);
  assign bus.act_rd_en_o    = rd_en;
  assign bus.wgt_rd_en_o    = rd_en;
  assign bus.act_rd_addr_o  = rd_en ? addr_q : '0;
  assign bus.wgt_rd_addr_o  = rd_en ? addr_q : '0;
  assign bus.mmu_valid_o    = vld_q[0];
  assign bus.result_valid_o = result_vld_q;
  assign bus.result_o       = result_q;

endmodule

// File: tb/tb_mmu_sequencer.sv
// Bench for mmu_sequencer: operand buffers and an output-stationary array model
// are attached; results are compared with matrix arithmetic on the buffer contents.
module tb_mmu_sequencer;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 32;
  localparam int KW = 8;
  localparam int VD = 2 * N - 2;

  logic clk = 1'b0;
  logic rst;

  mmu_sequencer_if #(.N(N), .DW(DW), .AW(AW), .KW(KW)) bus ();
  mmu_sequencer #(.N(N), .DW(DW), .AW(AW), .KW(KW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [N-1:0][DW-1:0] act_mem [256];
  logic [N-1:0][DW-1:0] wgt_mem [256];

  task automatic chk(input string nm, input logic [N*AW-1:0] a, input logic [N*AW-1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic chki(input string nm, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  function automatic logic [N-1:0][AW-1:0] ref_psum(input int k);
    logic [N-1:0][AW-1:0] res;
    int unsigned s;
    for (int r = 0; r < N; r++) begin
      s = 0;
      for (int kk = 0; kk < k; kk++)
        for (int c = 0; c < N; c++)
          s += int'(act_mem[kk][r]) * int'(wgt_mem[kk][c]);
      res[r] = s;
    end
    return res;
  endfunction

  // operand buffers: one-cycle read latency, junk on the bus when not reading
  logic          pen_a, pen_w;
  logic [KW-1:0] padr_a, padr_w;
  always @(negedge clk) begin
    pen_a  = bus.act_rd_en_o;
    pen_w  = bus.wgt_rd_en_o;
    padr_a = bus.act_rd_addr_o;
    padr_w = bus.wgt_rd_addr_o;
  end
  always @(posedge clk) begin
    #1;
    bus.act_rd_data_i = pen_a ? act_mem[padr_a] : (N*DW)'($urandom);
    bus.wgt_rd_data_i = pen_w ? wgt_mem[padr_w] : (N*DW)'($urandom);
  end

  // array model: PE(r,c) sees activation lane r delayed c and weight lane c delayed r
  int          t = 100;
  int          hold_until = 0;
  int unsigned a_h [64][N];
  int unsigned w_h [64][N];
  bit          v_h [64];
  int unsigned acc [N][N];
  logic        busy_prev = 1'b0;
  always @(posedge clk) t++;
  always @(negedge clk) begin
    int unsigned sum;
    if (rst || (bus.busy_o && !busy_prev))
      for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) acc[r][c] = 0;
    busy_prev = bus.busy_o;
    for (int r = 0; r < N; r++) begin
      a_h[t % 64][r] = int'(bus.mmu_act_o[r]);
      w_h[t % 64][r] = int'(bus.mmu_wgt_o[r]);
    end
    v_h[t % 64] = bus.mmu_valid_o;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        acc[r][c] += a_h[(t - c) % 64][r] * w_h[(t - r) % 64][c];
    bus.mmu_valid_i = v_h[(t - VD) % 64] || (t < hold_until);
    for (int r = 0; r < N; r++) begin
      sum = 0;
      for (int c = 0; c < N; c++) sum += acc[r][c];
      bus.mmu_psum_i[r] = sum;
    end
  end

  task automatic fill_random(input int k);
    for (int kk = 0; kk < k; kk++)
      for (int r = 0; r < N; r++) begin
        act_mem[kk][r] = DW'($urandom);
        wgt_mem[kk][r] = DW'($urandom);
      end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ctl"}, {bus.busy_o, bus.done_o, bus.act_rd_en_o, bus.wgt_rd_en_o,
                       bus.act_rd_addr_o, bus.wgt_rd_addr_o, bus.mmu_valid_o,
                       bus.mmu_act_o, bus.mmu_wgt_o, bus.result_valid_o}, '0);
    chk({nm, "_result"}, bus.result_o, '0);
  endtask

  // one pass with start sampled at rel 0; returns at the negedge of the done cycle
  task automatic run_pass(input int k, input int h, input bit keep_start);
    int rel, nrd, exp_done;
    bit seen;
    logic [N-1:0][AW-1:0] exp_res;
    exp_res  = ref_psum(k);
    exp_done = (k == 0) ? 1 : k + 3 + 2 * N + h;
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.k_len_i = KW'(k);
    hold_until  = t + k + 2 + 2 * N + h;
    rel = 0; nrd = 0; seen = 1'b0;
    while (!seen && rel < exp_done + 20) begin
      @(negedge clk);
      rel++;
      if (!keep_start) bus.start_i = 1'b0;
      if (bus.act_rd_en_o) begin
        chki("rd_addr", int'(bus.act_rd_addr_o), nrd);
        chki("wgt_addr", int'(bus.wgt_rd_addr_o), nrd);
        nrd++;
      end
      if (bus.done_o) seen = 1'b1;
    end
    chki($sformatf("done_cycle_k%0d", k), seen ? rel : -1, exp_done);
    chki($sformatf("reads_k%0d", k), nrd, k);
    chk($sformatf("result_k%0d", k), bus.result_o, exp_res);
    chk($sformatf("result_valid_k%0d", k), bus.result_valid_o, 1);
  endtask

  typedef struct {
    logic       start;
    logic       busy;
    logic       rd_en;
    logic [7:0] addr;
    logic       vld;
    logic [7:0] a0;
    logic [7:0] a3;
    logic [7:0] w3;
    logic       done;
  } vec_t;

  vec_t tbl [17];

  initial begin
    int rel, ndone;
    bit seen;

    for (int c = 0; c < 17; c++) begin
      tbl[c].start = (c == 0);
      tbl[c].busy  = (c >= 1 && c <= 15);
      tbl[c].rd_en = (c >= 1 && c <= 4);
      tbl[c].addr  = (c >= 1 && c <= 4) ? 8'(c - 1) : 8'd0;
      tbl[c].vld   = (c >= 3 && c <= 6);
      tbl[c].a0    = (c >= 3 && c <= 6) ? 8'(c - 2) : 8'd0;
      tbl[c].a3    = (c >= 6 && c <= 9) ? 8'(c - 5) : 8'd0;
      tbl[c].w3    = (c >= 6 && c <= 9) ? 8'd1 : 8'd0;
      tbl[c].done  = (c == 15);
    end

    // reset, with start pulsed while reset is held
    rst = 1'b1;
    bus.start_i = 1'b1;
    bus.k_len_i = 8'd5;
    repeat (3) @(negedge clk);
    chk_zero("in_reset");
    bus.start_i = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk_zero("after_reset");
    @(negedge clk);
    chk_zero("idle");

    // K=4 reference pass, checked cycle by cycle
    for (int kk = 0; kk < 4; kk++)
      for (int r = 0; r < N; r++) begin
        act_mem[kk][r] = 8'(kk + 1);
        wgt_mem[kk][r] = 8'd1;
      end
    hold_until = 0;
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      bus.start_i = tbl[c].start;
      bus.k_len_i = 8'd4;
      chk($sformatf("k4_cycle%0d", c),
          {bus.busy_o, bus.act_rd_en_o, bus.wgt_rd_en_o, bus.act_rd_addr_o,
           bus.wgt_rd_addr_o, bus.mmu_valid_o, bus.mmu_act_o[0], bus.mmu_act_o[N-1],
           bus.mmu_wgt_o[N-1], bus.done_o},
          {tbl[c].busy, tbl[c].rd_en, tbl[c].rd_en, tbl[c].addr, tbl[c].addr,
           tbl[c].vld, tbl[c].a0, tbl[c].a3, tbl[c].w3, tbl[c].done});
    end
    chk("k4_result", bus.result_o, ref_psum(4));
    chk("k4_result_valid", bus.result_valid_o, 1);

    // K=0 clears a non-zero result
    run_pass(0, 0, 1'b0);

    // start held high through a K=3 pass, then a second pass from the IDLE cycle
    fill_random(3);
    run_pass(3, 0, 1'b1);
    @(negedge clk);
    chk("held_idle_busy", bus.busy_o, 0);
    chk("held_idle_rvalid", bus.result_valid_o, 1);
    @(negedge clk);
    bus.start_i = 1'b0;
    chk("held_restart_busy", bus.busy_o, 1);
    chk("held_restart_rvalid", bus.result_valid_o, 0);
    rel = 1; seen = 1'b0;
    while (!seen && rel < 40) begin
      @(negedge clk);
      rel++;
      if (bus.done_o) seen = 1'b1;
    end
    chki("held_second_done", seen ? rel : -1, 14);
    chk("held_second_result", bus.result_o, ref_psum(3));

    // array keeps valid high 5 cycles past the drain window
    fill_random(4);
    run_pass(4, 5, 1'b0);

    // reset during DRAIN of a K=4 pass
    fill_random(4);
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.k_len_i = 8'd4;
    hold_until = 0;
    ndone = 0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      bus.start_i = 1'b0;
      if (bus.done_o) ndone++;
    end
    rst = 1'b1;
    #1;
    chk_zero("midpass_reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.done_o) ndone++;
    end
    chki("midpass_no_done", ndone, 0);
    chk("midpass_result_valid", bus.result_valid_o, 0);
    fill_random(4);
    run_pass(4, 0, 1'b0);

    // randomized passes
    for (int i = 0; i < 6; i++) begin
      int k, h;
      k = $urandom_range(1, 12);
      h = $urandom_range(0, 3);
      fill_random(k);
      run_pass(k, h, 1'b0);
    end

    // largest legal K: addresses must not wrap
    fill_random(255);
    run_pass(255, 0, 1'b0);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmu_sequencer.md
# mmu_sequencer

Controller that runs one matrix-multiply pass on the N×N systolic MMU array. On `start_i` it:
- reads K activation vectors and K weight vectors from two single-port operand buffers;
- applies the diagonal input skew the array needs and drives the array inputs with valid;
- waits for the array to drain, then captures the N row partial sums into a result register.

It sits between the operand buffers and the MMU array. Host/control logic issues one command per pass.

## Interface
- `N`, 4, array dimension (lanes)
- `DW`, 8, activation/weight element width
- `AW`, 32, partial-sum width (signed)
- `KW`, 8, width of K length and buffer address

- `clk` in 1: single clock, rising edge
- `rst` in 1: reset, asynchronous, active-high
- `start_i` in 1: command strobe, sampled only in IDLE
- `k_len_i` in KW: inner dimension K, sampled with `start_i`
- `busy_o` out 1: pass in progress
- `done_o` out 1: one-cycle pulse at end of pass
- `act_rd_en_o` out 1: activation buffer read enable
- `act_rd_addr_o` out KW: activation buffer address
- `act_rd_data_i` in DW×N: activation vector, valid the cycle after `act_rd_en_o`
- `wgt_rd_en_o` out 1: weight buffer read enable
- `wgt_rd_addr_o` out KW: weight buffer address
- `wgt_rd_data_i` in DW×N: weight vector, 1-cycle read latency
- `mmu_valid_o` out 1: to array `valid_i`
- `mmu_act_o` out DW×N: to array `activation_rows`
- `mmu_wgt_o` out DW×N: to array `weight_columns`
- `mmu_valid_i` in 1: from array `valid_o`
- `mmu_psum_i` in AW×N signed: from array `psum_rows`
- `result_valid_o` out 1: `result_o` holds a completed pass
- `result_o` out AW×N signed: captured partial sums

## Operation
- States:
  - IDLE: `start_i` high → FETCH with `k_len_i` latched. If `k_len_i`=0 → DONE directly, `result_o` cleared to 0.
  - FETCH: both read enables high, same address on both ports, address steps 0..K-1, one per cycle. After address K-1 is issued → DRAIN.
  - DRAIN: drain counter loads 0 on the cycle the last lane-0 valid leaves the skew stage and counts to 2N-1. When count = 2N-1 and `mmu_valid_i`=0, capture `mmu_psum_i` into `result_o` → DONE. If `mmu_valid_i` is still 1 at 2N-1, stay in DRAIN (counter saturates) until it drops; capture on that cycle.
  - DONE: `done_o`=1 for exactly one cycle; `result_valid_o` set → IDLE.
- Read-valid flag: read data is registered into skew stage 0 together with a read-valid flag.
- Skew: lane r (activations and weights alike) passes through r extra register stages beyond stage 0. Lane 0 therefore has 1 stage and lane N-1 has N stages.
  - Each stage loads zero when its associated valid is 0, so the array sees zeros outside the data window.
- `mmu_valid_o` = stage-0 valid, i.e. lane-0 timing. The array propagates valid internally.
- `busy_o` is high in FETCH, DRAIN and DONE.
- `result_valid_o` stays high, and `result_o` is held, until the next accepted start, which clears `result_valid_o`.
- `start_i` outside IDLE is ignored; no queueing.
- Buffer addresses are `KW` bits. K up to 2^KW-1 is legal, and the address never wraps within a pass.
- No arithmetic is performed; psums are captured bit-exact.

## Timing
- Reset values: all outputs 0. State IDLE, skew registers 0, counters 0, `result_o` 0, `result_valid_o` 0.
- Reset asserted mid-pass: immediate return to the reset values. No `done_o` is produced, and the aborted pass leaves no effects.
- Pass timeline, with start sampled in cycle 0:
  - `busy_o`=1 from cycle 1.
  - Reads issued cycles 1..K.
  - Read data at cycles 2..K+1.
  - `mmu_valid_o` and lane-0 data at cycles 3..K+2.
  - Lane r data at cycles 3+r..K+2+r.
- Drain counter = 0 at cycle K+3; capture at cycle K+2+2N at the earliest.
- `done_o`, and the rising edge of `result_valid_o`, come one cycle after capture.
- IDLE one cycle after DONE. A new start is accepted in that IDLE cycle.
- K=0: `busy_o` high and `done_o` pulse in cycle 1, no reads, `result_o`=0.

## Test plan
- Reset then idle: all outputs 0. `start_i` pulsed while `rst`=1 is ignored.
- N=4, K=4, act[k][r]=k+1, wgt[k][c]=1, array model attached:
  - reads at cycles 1..4, addresses 0..3;
  - `mmu_valid_o` cycles 3..6;
  - lane 3 data cycles 6..9;
  - `done_o` at cycle 15;
  - `result_o` matches the model psums.
- K=0: `done_o` at cycle 1, `result_o`=0, no read enables.
- `start_i` held high through an entire K=3 pass: exactly one pass runs. A second pass starts from the IDLE cycle after DONE, and `result_valid_o` drops on that acceptance.
- Model holds `mmu_valid_i` high 5 cycles past the drain window: capture is delayed until `mmu_valid_i`=0, and `done_o` follows one cycle later.
- `rst` asserted in DRAIN of a K=4 pass: outputs go to 0 immediately, no `done_o`, and a following pass completes normally.
